// File: rtl/mips_pkg.sv
// Shared opcodes, FSM state and write-back payload for the MIPS memory/write-back stage.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              en;
        logic              misalign;
        logic [4:0]        rd;
        logic [WORD_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word memory: synchronous write, asynchronous read, contents never reset.
module dmem_ram
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// Data-memory access and register write-back stage; stalls upstream while a multi-cycle load is pending.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        w_reg,
    input  logic [4:0]        r_reg2,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] r2_data,
    input  logic              wr_file,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_reg,
    output logic [WORD_W-1:0] wb_data,
    output logic              misalign
);

    localparam int unsigned CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [4:0]        rt_q, rt_d;
    logic              valid_q, valid_d;
    wb_req_t           wb_q, wb_d;

    logic              is_lw, is_sw, aligned;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr_hi;

    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign aligned  = (alu_result[1:0] == 2'b00);
    assign in_ready = (state_q == IDLE);

    // Stores never land while reset is held, even though the FSM looks idle then.
    assign ram_we   = rst && in_valid && in_ready && is_sw && aligned;
    assign ram_addr = (state_q == WAIT) ? idx_q : alu_result[ADDR_W+1:2];

    assign unused_addr_hi = ^alu_result[WORD_W-1:ADDR_W+2];

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (r2_data),
        .rdata_c (ram_rdata)
    );

    // Next-state and write-back request; reg/data hold unless a new result is produced.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rt_d        = rt_q;
        valid_d     = 1'b0;
        wb_d.en       = 1'b0;
        wb_d.misalign = 1'b0;
        wb_d.rd       = wb_q.rd;
        wb_d.data     = wb_q.data;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if ((is_lw || is_sw) && !aligned) begin
                        valid_d       = 1'b1;
                        wb_d.misalign = 1'b1;
                    end else if (is_lw) begin
                        if (LOAD_LAT == 1) begin
                            valid_d   = 1'b1;
                            wb_d.en   = (r_reg2 != 5'd0);
                            wb_d.rd   = r_reg2;
                            wb_d.data = ram_rdata;
                        end else begin
                            cnt_d   = CNT_W'(LOAD_LAT - 1);
                            idx_d   = alu_result[ADDR_W+1:2];
                            rt_d    = r_reg2;
                            state_d = WAIT;
                        end
                    end else if (opcode == OP_RTYPE) begin
                        valid_d   = 1'b1;
                        wb_d.en   = wr_file && (w_reg != 5'd0);
                        wb_d.rd   = w_reg;
                        wb_d.data = alu_result;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    valid_d   = 1'b1;
                    wb_d.en   = (rt_q != 5'd0);
                    wb_d.rd   = rt_q;
                    wb_d.data = ram_rdata;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rt_q    <= '0;
            valid_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rt_q    <= rt_d;
            valid_q <= valid_d;
            wb_q    <= wb_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_en    = wb_q.en;
    assign wb_reg   = wb_q.rd;
    assign wb_data  = wb_q.data;
    assign misalign = wb_q.misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver models each accepted instruction, monitor checks write-backs.
module tb_mem_wb_stage;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    localparam logic [5:0] T_RTYPE = 6'h00;
    localparam logic [5:0] T_LW    = 6'h23;
    localparam logic [5:0] T_SW    = 6'h2B;

    typedef struct {
        bit          en;
        bit          mis;
        bit          chk;
        logic [4:0]  rd;
        logic [31:0] data;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [4:0]  w_reg = '0;
    logic [4:0]  r_reg2 = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] r2_data = '0;
    logic        wr_file = 1'b0;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        misalign;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_until = 0;
    logic [31:0] mem_m [DEPTH];
    exp_t        exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_wb_stage #(
        .ADDR_W   (8),
        .LOAD_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .w_reg      (w_reg),
        .r_reg2     (r_reg2),
        .alu_result (alu_result),
        .r2_data    (r2_data),
        .wr_file    (wr_file),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .misalign   (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        return (cyc >= busy_until);
    endfunction

    // Reference behaviour: the accept lands on the next posedge, numbered cyc+1.
    task automatic model_accept();
        exp_t e;
        int   a;
        int   idx;
        bit   mis;
        a   = cyc + 1;
        idx = int'((alu_result >> 2) % 32'(DEPTH));
        mis = (alu_result[1:0] != 2'b00);
        e.en = 0; e.mis = 0; e.chk = 0; e.rd = '0; e.data = '0; e.t = a;
        if ((opcode == T_LW || opcode == T_SW) && mis) begin
            e.mis = 1;
        end else if (opcode == T_LW) begin
            e.en   = (r_reg2 != 0);
            e.chk  = 1;
            e.rd   = r_reg2;
            e.data = mem_m[idx];
            e.t    = a + LAT - 1;
            busy_until = a + LAT - 1;
        end else if (opcode == T_SW) begin
            mem_m[idx] = r2_data;
        end else if (opcode == T_RTYPE) begin
            e.en   = wr_file && (w_reg != 0);
            e.chk  = 1;
            e.rd   = w_reg;
            e.data = alu_result;
        end
        exp_q.push_back(e);
    endtask

    task automatic rand_inputs();
        opcode     = 6'($urandom);
        w_reg      = 5'($urandom);
        r_reg2     = 5'($urandom);
        alu_result = $urandom;
        r2_data    = $urandom;
        wr_file    = 1'($urandom);
    endtask

    // Entered at a negedge; holds the instruction until the model says it is accepted.
    task automatic send(input logic [5:0] op, input logic [4:0] wr, input logic [4:0] rr,
                        input logic [31:0] alu, input logic [31:0] r2, input logic wrf);
        opcode = op; w_reg = wr; r_reg2 = rr; alu_result = alu; r2_data = r2; wr_file = wrf;
        in_valid = 1'b1;
        while (!model_ready()) begin
            chk("in_ready_stall", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk("in_ready", 32'(in_ready), 32'd1);
        model_accept();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            rand_inputs();
            chk("in_ready_idle", 32'(in_ready), 32'(model_ready()));
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        #2;
        rst = 1'b0;
        exp_q.delete();
        busy_until = 0;
        repeat (n) begin
            in_valid = 1'($urandom);
            rand_inputs();
            @(negedge clk);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_random();
        int          r;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [5:0]  others [4];
        others = '{6'h08, 6'h0D, 6'h3F, 6'h2A};
        r   = $urandom_range(0, 9);
        alu = $urandom;
        if (r <= 2 || r == 9) op = T_RTYPE;
        else if (r <= 5) op = T_LW;
        else if (r <= 7) op = T_SW;
        else op = others[$urandom_range(0, 3)];
        if ((op == T_LW || op == T_SW) && $urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
        send(op, 5'($urandom), 5'($urandom_range(0, 31)), alu, $urandom, 1'($urandom));
    endtask

    // Monitor: every wb_valid pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: got wb_valid=1 expected none pending at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_time", 32'(cyc), 32'(e.t));
                    chk("wb_en", 32'(wb_en), 32'(e.en));
                    chk("wb_misalign", 32'(misalign), 32'(e.mis));
                    if (e.chk) begin
                        chk("wb_reg", 32'(wb_reg), 32'(e.rd));
                        chk("wb_data", wb_data, e.data);
                    end
                end
            end else begin
                chk("idle_wb_en", 32'(wb_en), 32'd0);
                chk("idle_misalign", 32'(misalign), 32'd0);
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0;
        in_valid = 1'($urandom);
        rand_inputs();
        repeat (3) @(negedge clk);
        do_reset(1);

        for (int i = 0; i < DEPTH; i++) begin
            send(T_SW, 5'($urandom), 5'($urandom), 32'(i * 4), $urandom, 1'b1);
        end

        send(T_SW, 5'd0, 5'd0, 32'h10, 32'hDEADBEEF, 1'b0);
        send(T_LW, 5'd0, 5'd5, 32'h10, 32'h0, 1'b0);
        idle(3);

        send(T_RTYPE, 5'd3, 5'd0, 32'h64, 32'h0, 1'b1);
        send(T_RTYPE, 5'd0, 5'd0, 32'h64, 32'h0, 1'b1);
        idle(1);

        send(T_SW, 5'd0, 5'd0, 32'h20, 32'hA5A5A5A5, 1'b0);
        send(T_SW, 5'd0, 5'd0, 32'h22, 32'h12345678, 1'b0);
        send(T_LW, 5'd0, 5'd7, 32'h20, 32'h0, 1'b0);
        send(T_LW, 5'd0, 5'd8, 32'h13, 32'h0, 1'b0);
        idle(2);

        send(T_LW, 5'd0, 5'd9, 32'h20, 32'h0, 1'b0);
        send(T_RTYPE, 5'd10, 5'd0, 32'h111, 32'h0, 1'b1);
        send(T_RTYPE, 5'd11, 5'd0, 32'h222, 32'h0, 1'b1);
        send(T_RTYPE, 5'd12, 5'd0, 32'h333, 32'h0, 1'b1);
        idle(2);

        send(T_SW, 5'd0, 5'd0, 32'h0, 32'hCAFEF00D, 1'b0);
        send(T_LW, 5'd0, 5'd1, 32'h400, 32'h0, 1'b0);
        idle(2);

        send(T_LW, 5'd0, 5'd4, 32'h10, 32'h0, 1'b0);
        do_reset(2);
        idle(2);
        send(T_LW, 5'd0, 5'd6, 32'h10, 32'h0, 1'b0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            send_random();
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Data-memory and write-back stage directly downstream of the ALU.
- Accepts one decoded instruction per handshake: opcode, destination fields, ALU result and rt data.
- Performs the word load/store against a local data memory and produces a single registered write-back request for the register file.
- Loads see a configurable memory latency, and the stage back-pressures upstream while a load is in flight.

Parameters:
- ADDR_W, 8: word-address width; data memory depth is 2**ADDR_W 32-bit words.
- LOAD_LAT, 2: cycles from load accept to wb_valid; legal values are 1 or more.

Ports:
- clk  input  1  stage clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid and in_ready are both high at a clk edge.
- opcode  input  6  instruction opcode.
- w_reg  input  5  rd, the R-type destination.
- r_reg2  input  5  rt, the load destination.
- alu_result  input  32  ALU result; for lw/sw it is the byte address.
- r2_data  input  32  rt register value, used as store data.
- wr_file  input  1  ALU write-enable for R-type results.
- wb_valid  output  1  one-cycle pulse, one per accepted instruction.
- wb_en  output  1  register-file write enable, qualified by wb_valid.
- wb_reg  output  5  write-back register index.
- wb_data  output  32  write-back data.
- misalign  output  1  accepted lw/sw had alu_result[1:0] != 0; valid with wb_valid.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE and the counter clears.
  - wb_valid, wb_en, misalign, wb_reg and wb_data all go to 0.
  - in_ready is 1 from the first cycle after reset release.
  - Memory contents are not reset.
- Opcodes: LW = 6'h23, SW = 6'h2B. R-type = 6'h00. Any other opcode is "other".
- Memory indexing: word index = alu_result[ADDR_W+1:2]. Higher address bits are ignored, so addresses alias and wrap modulo the memory depth.
- FSM states:
  - IDLE: in_ready = 1.
  - WAIT: in_ready = 0; in_valid is ignored and nothing is captured.
- Accept in IDLE, by operation:
  - R-type: next cycle wb_valid = 1, wb_reg = w_reg, wb_data = alu_result, wb_en = wr_file && (w_reg != 0).
  - SW, aligned: memory word is written at the accept edge. Next cycle wb_valid = 1, wb_en = 0.
  - LW, aligned, LOAD_LAT = 1: next cycle wb_valid = 1, wb_reg = r_reg2, wb_data = mem[index], wb_en = (r_reg2 != 0). State stays IDLE.
  - LW, aligned, LOAD_LAT > 1: capture index and rt, load the counter with LOAD_LAT-1, go to WAIT.
  - LW/SW, misaligned: no memory access. Next cycle wb_valid = 1, wb_en = 0, misalign = 1.
  - Other opcode: next cycle wb_valid = 1, wb_en = 0.
- WAIT: the counter decrements every cycle. At the edge where the counter is 1, the stage issues the load write-back (wb_data read from the captured index at that edge) and returns to IDLE.
- Load timing: wb_valid rises exactly LOAD_LAT cycles after the accept edge. in_ready is low for LOAD_LAT-1 cycles.
- Outputs: all registered. wb_valid is high for exactly one cycle per accept. When wb_valid = 0, wb_en = 0 and misalign = 0; wb_reg and wb_data hold their last values.
- Ordering: a store followed immediately by a load to the same word returns the new data.
- Throughput: one instruction per cycle when no load is waiting.
- Register $0 is never written: wb_en is forced to 0 when the destination is 0.
- Reset mid-WAIT: the in-flight load is discarded, no wb_valid pulse is produced, and a pending store is unaffected because it has already completed.

Decomposition:
- mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW;
  - the FSM state enum {IDLE, WAIT};
  - the word-width constant 32.
- Sub-module dmem_ram #(ADDR_W): synchronous write, asynchronous read, one port; no reset.
- mem_wb_stage owns the FSM, the counter, the capture registers and the write-back output registers.

Test Plan:
- Reset: hold rst low for 3 cycles with random inputs. Required: wb_valid = wb_en = misalign = 0, wb_data = 0, in_ready = 1 after release.
- Store then load: SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 rt=5 (LOAD_LAT=2). Required:
  - SW produces wb_valid with wb_en = 0;
  - LW produces wb_valid 2 cycles after its accept with wb_en = 1, wb_reg = 5, wb_data = 0xDEADBEEF;
  - in_ready is low for exactly 1 cycle.
- R-type: wr_file=1, w_reg=3, result 0x64. Required: next cycle wb_en = 1, wb_reg = 3, wb_data = 0x64. Repeat with w_reg=0: required wb_valid = 1, wb_en = 0.
- Misalignment: SW 0x12345678 at addr 0x22, then LW addr 0x20 after a prior SW of 0xA5A5A5A5 to 0x20. Required: misalign pulses for the SW, and the load returns 0xA5A5A5A5. LW at 0x13: required misalign = 1, wb_en = 0.
- Reset during WAIT: LOAD_LAT=4, assert rst 2 cycles after the LW accept. Required: no wb_valid pulse; in_ready = 1 after release.
- Back-pressure and streaming:
  - Hold in_valid high with an LW followed by three R-types. Required: the R-types are accepted only once in_ready returns, producing wb_valid on 4 consecutive cycles in order.
  - Address 0x400 with ADDR_W=8 aliases to word 0.
